// File: rtl/sum3_divider_if.sv
// Handshake bundle for sum3_divider.
// The upstream side drives the operands and out_ready; the divider drives in_ready and the result.
interface sum3_divider_if #(
    parameter int DW = 6,
    parameter int VW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/sum3_divider.sv
// Sequential restoring divider for the 6-bit output of the three-operand adder.
// It produces one quotient bit per clock and has valid/ready handshakes on both sides.
// Divide by zero takes the full latency and returns all-ones, remainder 0 and div_zero set.
module sum3_divider #(
    parameter int DW = 6,
    parameter int VW = 4
) (
    input  logic            clk,
    input  logic            rst,
    sum3_divider_if.slave   bus
);
    localparam int CW = $clog2(DW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [VW:0]   rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] remo_q, remo_d;
    logic          dz_q, dz_d;

    logic [VW+1:0] rem_wide;
    logic [VW+1:0] trial;
    logic          q_bit;
    logic [VW:0]   rem_step;
    logic [DW-1:0] quot_step;
    logic          dvs_zero;

    // One restoring step: bring in the next dividend bit, trial-subtract, keep or restore.
    always_comb begin
        rem_wide  = {rem_q, shift_q[DW-1]};
        trial     = rem_wide - {2'b00, dvs_q};
        q_bit     = ~trial[VW+1];
        rem_step  = q_bit ? trial[VW:0] : rem_wide[VW:0];
        quot_step = {shift_q[DW-2:0], q_bit};
        dvs_zero  = (dvs_q == '0);
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, hold the result in DONE until consumed.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_BUSY;
                    shift_d = bus.dividend;
                    dvs_d   = bus.divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(DW - 1);
                end
            end
            ST_BUSY: begin
                shift_d = quot_step;
                rem_d   = rem_step;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    quot_d  = dvs_zero ? '1 : quot_step;
                    remo_d  = dvs_zero ? '0 : rem_step[VW-1:0];
                    dz_d    = dvs_zero;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = remo_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_sum3_divider.sv
// Self-checking bench for sum3_divider.
// It runs a table of directed vectors, hand-written back-pressure and reset sequences,
// and a full dividend x divisor sweep with random stalls checked against an arithmetic model.
module tb_sum3_divider;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   failures = 0;

    sum3_divider_if bus ();

    sum3_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [3:0] b;
        logic [5:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs one operation end to end and checks latency, result, hold under stall and return to IDLE.
    task automatic applyStimulus(input logic [5:0] a, input logic [3:0] b, input int stall,
                                 input logic [5:0] eq, input logic [3:0] er, input logic ez,
                                 input string name, output logic [5:0] q, output logic [3:0] r);
        int waitc;
        int lat;
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput({name, " in_ready before accept"}, int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = 6'($urandom);
        bus.divisor  = 4'($urandom);
        checkOutput({name, " in_ready after accept"}, int'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " latency"}, lat, 6);
        checkOutput({name, " quotient"}, int'(bus.quotient), int'(eq));
        checkOutput({name, " remainder"}, int'(bus.remainder), int'(er));
        checkOutput({name, " div_zero"}, int'(bus.div_zero), int'(ez));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput({name, " stall out_valid"}, int'(bus.out_valid), 1);
            checkOutput({name, " stall in_ready"}, int'(bus.in_ready), 0);
        end
        q = bus.quotient;
        r = bus.remainder;
        if (stall > 0) begin
            checkOutput({name, " held quotient"}, int'(q), int'(eq));
            checkOutput({name, " held remainder"}, int'(r), int'(er));
            checkOutput({name, " held div_zero"}, int'(bus.div_zero), int'(ez));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({name, " in_ready after consume"}, int'(bus.in_ready), 1);
        checkOutput({name, " out_valid after consume"}, int'(bus.out_valid), 0);
    endtask

    // Time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [5:0] q;
        logic [3:0] r;
        int         lat;
        int         eq;
        int         er;
        int         ez;

        vecs[0] = '{6'd45, 4'd3,  6'd15, 4'd0, 1'b0};
        vecs[1] = '{6'd46, 4'd3,  6'd15, 4'd1, 1'b0};
        vecs[2] = '{6'd5,  4'd9,  6'd0,  4'd5, 1'b0};
        vecs[3] = '{6'd63, 4'd1,  6'd63, 4'd0, 1'b0};
        vecs[4] = '{6'd63, 4'd15, 6'd4,  4'd3, 1'b0};
        vecs[5] = '{6'd20, 4'd0,  6'd63, 4'd0, 1'b1};
        vecs[6] = '{6'd44, 4'd3,  6'd14, 4'd2, 1'b0};
        vecs[7] = '{6'd0,  4'd7,  6'd0,  4'd0, 1'b0};
        vecs[8] = '{6'd7,  4'd2,  6'd3,  4'd1, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        #1;
        checkOutput("reset in_ready", int'(bus.in_ready), 1);
        checkOutput("reset out_valid", int'(bus.out_valid), 0);
        checkOutput("reset quotient", int'(bus.quotient), 0);
        checkOutput("reset remainder", int'(bus.remainder), 0);
        checkOutput("reset div_zero", int'(bus.div_zero), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, i % 3, vecs[i].q, vecs[i].r, vecs[i].dz,
                          $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b), q, r);
        end

        // Back-pressure with in_valid held high and operands changing throughout.
        bus.in_valid = 1'b1;
        bus.dividend = 6'd44;
        bus.divisor  = 4'd3;
        @(negedge clk);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.dividend = 6'($urandom);
            bus.divisor  = 4'($urandom);
            checkOutput("bp in_ready while busy", int'(bus.in_ready), 0);
            @(negedge clk);
            lat++;
        end
        checkOutput("bp latency", lat, 6);
        for (int i = 0; i < 10; i++) begin
            bus.dividend = 6'($urandom);
            bus.divisor  = 4'($urandom);
            checkOutput("bp out_valid", int'(bus.out_valid), 1);
            checkOutput("bp in_ready", int'(bus.in_ready), 0);
            checkOutput("bp quotient", int'(bus.quotient), 14);
            checkOutput("bp remainder", int'(bus.remainder), 2);
            checkOutput("bp div_zero", int'(bus.div_zero), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("bp consume out_valid", int'(bus.out_valid), 0);
        checkOutput("bp consume in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        checkOutput("bp no second accept in_ready", int'(bus.in_ready), 1);
        checkOutput("bp no second accept out_valid", int'(bus.out_valid), 0);

        // Reset in the middle of an operation, then a fresh operation.
        bus.in_valid = 1'b1;
        bus.dividend = 6'd45;
        bus.divisor  = 4'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset in_ready", int'(bus.in_ready), 1);
        checkOutput("midreset out_valid", int'(bus.out_valid), 0);
        checkOutput("midreset quotient", int'(bus.quotient), 0);
        checkOutput("midreset remainder", int'(bus.remainder), 0);
        checkOutput("midreset div_zero", int'(bus.div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(6'd7, 4'd2, 0, 6'd3, 4'd1, 1'b0, "after reset 7/2", q, r);

        // Full sweep against the arithmetic reference model with random stalls.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 63;
                    er = 0;
                    ez = 1;
                end else begin
                    eq = a / b;
                    er = a % b;
                    ez = 0;
                end
                applyStimulus(6'(a), 4'(b), int'($urandom_range(0, 3)), 6'(eq), 4'(er), 1'(ez),
                              $sformatf("sweep %0d/%0d", a, b), q, r);
                if (b != 0) begin
                    checkOutput($sformatf("sweep %0d/%0d invariant", a, b),
                                int'(q) * b + int'(r), a);
                    checkOutput($sformatf("sweep %0d/%0d rem below divisor", a, b),
                                int'(int'(r) < b), 1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
